// File: rtl/jtag_vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : jtag_vreg_bank
// Purpose  : Virtual-JTAG instruction register bank. It provides a bypass
//            register, a read-only capture of in_bus, and N_OUT writable
//            output registers, each with its own readback instruction.
//            Updates are synchronous to tck and raise a one-cycle strobe
//            for each channel.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_vreg_bank #(
  parameter int                DR_W    = 8,
  parameter int                IN_W    = 4,
  parameter int                N_OUT   = 2,
  parameter int                IR_W    = 3,
  parameter logic [DR_W-1:0]   OUT_RST = '0
) (
  input  logic                    tck,
  input  logic                    aclr,
  input  logic                    tdi,
  input  logic [IR_W-1:0]         ir_in,
  input  logic                    v_cdr,
  input  logic                    v_sdr,
  input  logic                    v_udr,
  input  logic                    v_uir,
  input  logic [IN_W-1:0]         in_bus,
  output logic                    tdo,
  output logic [N_OUT*DR_W-1:0]   outs,
  output logic [N_OUT-1:0]        upd_strobe
);

  localparam logic [IR_W-1:0] c_IR_READ_IN = IR_W'(1);

  logic                  r_byp;
  logic [DR_W-1:0]       r_dr;
  logic [DR_W-1:0]       r_out [N_OUT];
  logic [N_OUT-1:0]      r_pend;
  logic [N_OUT-1:0]      r_strobe;
  logic                  r_udr_q;

  logic [N_OUT-1:0]      w_wr_sel;
  logic [N_OUT-1:0]      w_rd_sel;
  logic                  w_is_read_in;
  logic                  w_is_bypass;
  logic [DR_W-1:0]       w_cap_val;
  logic [DR_W-1:0]       w_in_ext;

  // Per-channel instruction decode: WRITE_OUT k = 2+2k, READ_OUT k = 3+2k
  genvar g;
  generate
    for (g = 0; g < N_OUT; g++) begin : g_dec
      assign w_wr_sel[g] = (ir_in == IR_W'(2 + 2*g));
      assign w_rd_sel[g] = (ir_in == IR_W'(3 + 2*g));
      assign outs[g*DR_W +: DR_W] = r_out[g];
    end
  endgenerate

  assign w_is_read_in = (ir_in == c_IR_READ_IN);
  // Any code that selects no register (including unused codes) acts as BYPASS
  assign w_is_bypass  = !w_is_read_in && !(|w_wr_sel) && !(|w_rd_sel);
  assign w_in_ext     = DR_W'(in_bus);
  assign upd_strobe   = r_strobe;
  assign tdo          = w_is_bypass ? r_byp : r_dr[0];

  // Select the output register that a capture under READ_OUT/WRITE_OUT loads
  always_comb begin
    w_cap_val = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (w_wr_sel[k] || w_rd_sel[k]) begin
        w_cap_val = r_out[k];
      end
    end
  end

  // Capture/shift path: update-IR flush beats capture, and capture beats shift
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_dr  <= '0;
      r_byp <= 1'b0;
    end else if (v_uir) begin
      r_dr  <= '0;
      r_byp <= 1'b0;
    end else if (v_cdr) begin
      if (w_is_read_in) begin
        r_dr <= w_in_ext;
      end else if (w_is_bypass) begin
        r_byp <= 1'b0;
      end else begin
        r_dr <= w_cap_val;
      end
    end else if (v_sdr) begin
      if (w_is_bypass) begin
        r_byp <= tdi;
      end else begin
        r_dr <= {tdi, r_dr[DR_W-1:1]};
      end
    end
  end

  // Update path: load on every v_udr edge, strobe once per rising v_udr a cycle later
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      for (int k = 0; k < N_OUT; k++) begin
        r_out[k] <= OUT_RST;
      end
      r_pend   <= '0;
      r_strobe <= '0;
      r_udr_q  <= 1'b0;
    end else begin
      r_udr_q  <= v_udr;
      r_strobe <= r_pend;
      for (int k = 0; k < N_OUT; k++) begin
        r_pend[k] <= v_udr && !r_udr_q && w_wr_sel[k];
        if (v_udr && w_wr_sel[k]) begin
          r_out[k] <= r_dr;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_vreg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_vreg_bank
// Purpose  : Scoreboard bench for jtag_vreg_bank (DR_W=8, IN_W=4, N_OUT=2,
//            IR_W=3). Stimulus pushes the expected post-edge values, and a
//            monitor compares them one tck later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_vreg_bank;

  logic        tck;
  logic        aclr;
  logic        tdi;
  logic [2:0]  ir_in;
  logic        v_cdr, v_sdr, v_udr, v_uir;
  logic [3:0]  in_bus;
  logic        tdo;
  logic [15:0] outs;
  logic [1:0]  upd_strobe;

  jtag_vreg_bank #(
    .DR_W(8), .IN_W(4), .N_OUT(2), .IR_W(3), .OUT_RST(8'h00)
  ) dut (
    .tck(tck), .aclr(aclr), .tdi(tdi), .ir_in(ir_in),
    .v_cdr(v_cdr), .v_sdr(v_sdr), .v_udr(v_udr), .v_uir(v_uir),
    .in_bus(in_bus), .tdo(tdo), .outs(outs), .upd_strobe(upd_strobe)
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  int n_checks = 0;
  int n_pass   = 0;
  int mon_cyc  = 0;

  // Scoreboard: target edge count, observed field (0=tdo,1=outs,2=strobe), value, name
  int          q_cyc  [$];
  int          q_sel  [$];
  logic [15:0] q_exp  [$];
  string       q_name [$];

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      0:       observe = {15'b0, tdo};
      1:       observe = outs;
      default: observe = {14'b0, upd_strobe};
    endcase
  endfunction

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expectation for the state right after the next posedge
  task automatic push(input string name, input int sel, input logic [15:0] exp);
    q_cyc.push_back(mon_cyc + 1);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_name.push_back(name);
  endtask

  // Monitor: 1 ns after each edge, retire every expectation due by now
  initial begin
    forever begin
      @(posedge tck);
      #1;
      mon_cyc++;
      while (q_cyc.size() > 0 && q_cyc[0] <= mon_cyc) begin
        compare(q_name[0], observe(q_sel[0]), q_exp[0]);
        void'(q_cyc.pop_front());
        void'(q_sel.pop_front());
        void'(q_exp.pop_front());
        void'(q_name.pop_front());
      end
    end
  end

  // Drive strobes at a negedge and let one posedge consume them
  task automatic tick(input logic c, input logic s, input logic u, input logic ui, input logic t);
    v_cdr = c; v_sdr = s; v_udr = u; v_uir = ui; tdi = t;
    @(negedge tck);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] bits;
    logic [7:0] pat4;
    aclr = 1'b0; tdi = 1'b0; ir_in = 3'd0; in_bus = 4'd0;
    v_cdr = 1'b0; v_sdr = 1'b0; v_udr = 1'b0; v_uir = 1'b0;
    @(negedge tck);

    // Reset state
    push("rst_outs", 1, 16'h0000);
    push("rst_strobe", 2, 16'h0000);
    push("rst_tdo", 0, 16'h0000);
    tick(0, 0, 0, 0, 0);
    aclr = 1'b1;
    tick(0, 0, 0, 0, 0);

    // WRITE_OUT 1: shift 0xA5 in and update
    ir_in = 3'd4;
    bits = 8'hA5;
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, bits[i]);
    push("wr1_outs", 1, 16'hA500);
    push("wr1_strobe_e0", 2, 16'h0000);
    tick(0, 0, 1, 0, 0);
    push("wr1_strobe_e1", 2, 16'h0002);
    tick(0, 0, 0, 0, 0);
    push("wr1_strobe_e2", 2, 16'h0000);
    push("wr1_outs_hold", 1, 16'hA500);
    tick(0, 0, 0, 0, 0);

    // READ_OUT 1: capture then shift out, LSB first
    ir_in = 3'd5;
    push("rd1_cap_tdo", 0, 16'h0001);
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      push($sformatf("rd1_tdo_%0d", i), 0, (i < 8) ? {15'b0, bits[i]} : 16'h0000);
      tick(0, 1, 0, 0, 0);
    end
    push("rd1_outs_kept", 1, 16'hA500);
    tick(0, 0, 0, 0, 0);

    // READ_IN: zero-extended capture, then update must do nothing
    ir_in = 3'd1; in_bus = 4'b1011;
    bits = 8'h0B;
    push("rdin_cap_tdo", 0, 16'h0001);
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i < 8; i++) begin
      push($sformatf("rdin_tdo_%0d", i), 0, {15'b0, bits[i]});
      tick(0, 1, 0, 0, 0);
    end
    push("rdin_udr_outs", 1, 16'hA500);
    tick(0, 0, 1, 0, 0);
    push("rdin_udr_strobe1", 2, 16'h0000);
    tick(0, 0, 0, 0, 0);
    push("rdin_udr_strobe2", 2, 16'h0000);
    tick(0, 0, 0, 0, 0);

    // BYPASS (code 0) and unused code 7: tdo is tdi delayed one tck, dr untouched
    tick(1, 0, 0, 0, 0);                 // dr = 0x0B under READ_IN
    pat4 = 8'b0000_1011;                  // tdi pattern 1,1,0,1 (bit 0 first)
    ir_in = 3'd0;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("byp0_tdo_%0d", i), 0, {15'b0, pat4[i]});
      tick(0, 1, 0, 0, pat4[i]);
    end
    ir_in = 3'd7;
    for (int i = 0; i < 4; i++) begin
      push($sformatf("byp7_tdo_%0d", i), 0, {15'b0, pat4[i]});
      tick(0, 1, 0, 0, pat4[i]);
    end
    ir_in = 3'd1;
    push("dr_kept_bit0", 0, 16'h0001);
    tick(0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      push($sformatf("dr_kept_bit%0d", i), 0, {15'b0, bits[i]});
      tick(0, 1, 0, 0, 0);
    end

    // Update-IR flushes dr = 0xFF
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, 1);
    push("ff_tdo", 0, 16'h0001);
    tick(0, 0, 0, 0, 0);
    push("uir_flush_tdo", 0, 16'h0000);
    tick(0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      push($sformatf("uir_flush_shift%0d", i), 0, 16'h0000);
      tick(0, 1, 0, 0, 0);
    end
    // Update-IR also clears bypass
    ir_in = 3'd0;
    push("byp_set", 0, 16'h0001);
    tick(0, 1, 0, 0, 1);
    push("uir_byp_clear", 0, 16'h0000);
    tick(0, 0, 0, 1, 0);

    // Capture and shift together: capture wins
    ir_in = 3'd1; in_bus = 4'b1011;
    push("cdr_sdr_tdo", 0, 16'h0001);
    tick(1, 1, 0, 0, 1);
    push("cdr_sdr_bit1", 0, 16'h0001);
    tick(0, 1, 0, 0, 0);
    push("cdr_sdr_bit2", 0, 16'h0000);
    tick(0, 1, 0, 0, 0);

    // WRITE_OUT 0 with v_udr held three cycles: single strobe
    ir_in = 3'd2;
    bits = 8'h3C;
    for (int i = 0; i < 8; i++) tick(0, 1, 0, 0, bits[i]);
    push("hold_outs", 1, 16'hA53C);
    push("hold_strobe_e0", 2, 16'h0000);
    tick(0, 0, 1, 0, 0);
    push("hold_strobe_e1", 2, 16'h0001);
    tick(0, 0, 1, 0, 0);
    push("hold_strobe_e2", 2, 16'h0000);
    tick(0, 0, 1, 0, 0);
    push("hold_strobe_e3", 2, 16'h0000);
    push("hold_outs_after", 1, 16'hA53C);
    tick(0, 0, 0, 0, 0);

    // Asynchronous reset mid-shift with dr non-zero
    ir_in = 3'd1; in_bus = 4'b1011;
    push("pre_rst_cap", 0, 16'h0001);
    tick(1, 0, 0, 0, 0);
    push("pre_rst_shift", 0, 16'h0001);
    tick(0, 1, 0, 0, 1);
    #2;
    aclr = 1'b0;
    #1;
    compare("async_rst_tdo", {15'b0, tdo}, 16'h0000);
    compare("async_rst_outs", outs, 16'h0000);
    compare("async_rst_strobe", {14'b0, upd_strobe}, 16'h0000);
    @(negedge tck);
    aclr = 1'b1;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);

    if (q_cyc.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_cyc.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
